// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between ifu_fetch and instruction memory.
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding imem requests feeding a one-entry IF/ID slot.
// Optional IFU_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag on unaligned redirects.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  ifu_fetch_if.master imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] slot_pc;
  logic [31:0] slot_instr;
  logic        slot_v;
  logic [31:0] redirect_eff;
  logic        blocked;
  logic        consume;
  logic        capture;
  logic        req_fire;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q;

  assign redirect_eff     = redirect_pc;
  assign blocked          = mis_q;
  assign fetch_misaligned = mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (flush) begin
      mis_q <= |redirect_pc[1:0];
    end
  end
`else
  assign redirect_eff = redirect_pc & 32'hFFFF_FFFC;
  assign blocked      = 1'b0;
`endif

  assign consume = slot_v & ~pause & ~flush;
  assign capture = (state_q == S_WAIT) & imem.rvalid & ~flush;

  // A misaligned redirect still follows the normal flush transitions, so an
  // in-flight response is drained in DROP before any later aligned redirect.
  always_comb begin
    state_d  = state_q;
    req_fire = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (!flush && !rst && !blocked && (!slot_v || consume)) begin
          req_fire = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          state_d = S_REQ;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem.rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem.req  = req_fire;
  assign imem.addr = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (flush) begin
      pc_q <= redirect_eff;
    end else if (capture) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Slot registers are cleared to the empty-slot output values so the
  // IF/ID outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot_v     <= 1'b0;
      slot_pc    <= '0;
      slot_instr <= NOP_INSTR;
    end else if (capture) begin
      slot_v     <= 1'b1;
      slot_pc    <= pc_q;
      slot_instr <= imem.rdata;
    end else if (consume) begin
      slot_v     <= 1'b0;
      slot_pc    <= '0;
      slot_instr <= NOP_INSTR;
    end
  end

  assign if_valid = slot_v;
  assign if_pc    = slot_pc;
  assign if_instr = slot_instr;

endmodule
